// File: rtl/rpn_stack_driver.sv
// rpn_stack_driver: evaluates RPN tokens (push literal, add, sub, peek)
// against an external 5-entry, 4-bit stack, tracking depth so the stack
// never overflows or underflows, and reports one result or error per
// arithmetic or peek token.
module rpn_stack_driver (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TOK_VALID,
    output logic       TOK_READY,
    input  logic [1:0] TOK_OP,
    input  logic [3:0] TOK_DATA,
    output logic       RES_VALID,
    output logic [3:0] RES_DATA,
    output logic       RES_ERR,
    output logic [1:0] STK_COMMAND,
    output logic [2:0] STK_INDEX,
    output logic [3:0] STK_I_DATA,
    input  logic [3:0] STK_O_DATA,
    output logic       STK_RESET
);

    localparam int         DATA_W    = 4;
    localparam logic [2:0] MAX_DEPTH = 3'd5;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_B,
        POP_A,
        PUSH_R,
        PEEK
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          depth;
    logic [DATA_W-1:0]   lit_q;
    logic [2:0]          idx_q;
    logic                is_sub_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   result;
    logic                hs;
    logic                tok_err;

    // Modulo-16 add; the carry out is simply dropped.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W-1:0];
    endfunction

    // Modulo-16 subtract; the borrow is simply dropped.
    function automatic logic [DATA_W-1:0] wrap_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[DATA_W-1:0];
    endfunction

    assign STK_RESET = RESET;
    assign TOK_READY = (state == IDLE);
    assign hs        = TOK_VALID && (state == IDLE);
    assign STK_INDEX = idx_q;
    assign result    = is_sub_q ? wrap_sub(a_q, b_q) : wrap_add(a_q, b_q);

    // Decide whether the offered token would overflow, underflow or read past the stack.
    always_comb begin
        tok_err = 1'b0;
        case (TOK_OP)
            OP_PUSH:        tok_err = (depth == MAX_DEPTH);
            OP_ADD, OP_SUB: tok_err = (depth < 3'd2);
            default:        tok_err = (TOK_DATA[2:0] >= depth);
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and the stack command issued in each state.
    always_comb begin
        state_nxt   = state;
        STK_COMMAND = CMD_NOP;
        STK_I_DATA  = lit_q;
        case (state)
            IDLE: begin
                if (hs && !tok_err) begin
                    case (TOK_OP)
                        OP_PUSH:        state_nxt = PUSH;
                        OP_ADD, OP_SUB: state_nxt = POP_B;
                        default:        state_nxt = PEEK;
                    endcase
                end
            end
            PUSH: begin
                STK_COMMAND = CMD_PUSH;
                state_nxt   = IDLE;
            end
            POP_B: begin
                STK_COMMAND = CMD_POP;
                state_nxt   = POP_A;
            end
            POP_A: begin
                STK_COMMAND = CMD_POP;
                state_nxt   = PUSH_R;
            end
            PUSH_R: begin
                STK_COMMAND = CMD_PUSH;
                STK_I_DATA  = result;
                state_nxt   = IDLE;
            end
            PEEK: begin
                STK_COMMAND = CMD_GET;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Token latching, operand capture, depth tracking and result reporting.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            depth     <= 3'd0;
            lit_q     <= '0;
            idx_q     <= 3'd0;
            is_sub_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_ERR   <= 1'b0;
        end else begin
            RES_VALID <= 1'b0;
            RES_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        lit_q    <= TOK_DATA;
                        idx_q    <= TOK_DATA[2:0];
                        is_sub_q <= (TOK_OP == OP_SUB);
                        if (tok_err) begin
                            RES_VALID <= 1'b1;
                            RES_ERR   <= 1'b1;
                            RES_DATA  <= '0;
                        end
                    end
                end
                PUSH: begin
                    depth <= depth + 3'd1;
                end
                POP_B: begin
                    b_q   <= STK_O_DATA;
                    depth <= depth - 3'd1;
                end
                POP_A: begin
                    a_q   <= STK_O_DATA;
                    depth <= depth - 3'd1;
                end
                PUSH_R: begin
                    depth     <= depth + 3'd1;
                    RES_VALID <= 1'b1;
                    RES_DATA  <= result;
                end
                PEEK: begin
                    RES_VALID <= 1'b1;
                    RES_DATA  <= STK_O_DATA;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_driver.sv
// Testbench for rpn_stack_driver: a behavioural stack sits on the stack
// port, and a queue-based RPN evaluator predicts every command and result.
module tb_rpn_stack_driver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TOK_VALID;
    logic       TOK_READY;
    logic [1:0] TOK_OP;
    logic [3:0] TOK_DATA;
    logic       RES_VALID;
    logic [3:0] RES_DATA;
    logic       RES_ERR;
    logic [1:0] STK_COMMAND;
    logic [2:0] STK_INDEX;
    logic [3:0] STK_I_DATA;
    logic [3:0] STK_O_DATA;
    logic       STK_RESET;

    int total  = 0;
    int passed = 0;

    logic [3:0] ref_stk[$];
    logic [3:0] last_res = 4'h0;

    logic [3:0] smem[0:7];
    int         sp = 0;

    rpn_stack_driver dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TOK_VALID   (TOK_VALID),
        .TOK_READY   (TOK_READY),
        .TOK_OP      (TOK_OP),
        .TOK_DATA    (TOK_DATA),
        .RES_VALID   (RES_VALID),
        .RES_DATA    (RES_DATA),
        .RES_ERR     (RES_ERR),
        .STK_COMMAND (STK_COMMAND),
        .STK_INDEX   (STK_INDEX),
        .STK_I_DATA  (STK_I_DATA),
        .STK_O_DATA  (STK_O_DATA),
        .STK_RESET   (STK_RESET)
    );

    always #5 CLK = ~CLK;

    // Behavioural stack: commits pushes/pops at the closing edge, reset clears it.
    always @(posedge CLK) begin
        if (STK_RESET) begin
            sp <= 0;
        end else begin
            case (STK_COMMAND)
                2'b01: if (sp < 8) begin
                    smem[3'(sp)] <= STK_I_DATA;
                    sp <= sp + 1;
                end
                2'b10: if (sp > 0) sp <= sp - 1;
                default: ;
            endcase
        end
    end

    // Stack read data during pop/get cycles.
    always_comb begin
        STK_O_DATA = 4'h0;
        if (STK_COMMAND == 2'b10 && sp > 0)
            STK_O_DATA = smem[3'(sp - 1)];
        else if (STK_COMMAND == 2'b11 && int'(STK_INDEX) < sp)
            STK_O_DATA = smem[3'(sp - 1 - int'(STK_INDEX))];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        TOK_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_res_valid", int'(RES_VALID), 0);
        chk("rst_res_data", int'(RES_DATA), 0);
        chk("rst_res_err", int'(RES_ERR), 0);
        chk("rst_stk_cmd", int'(STK_COMMAND), 0);
        chk("rst_stk_index", int'(STK_INDEX), 0);
        chk("rst_stk_i_data", int'(STK_I_DATA), 0);
        chk("rst_stk_reset", int'(STK_RESET), 1);
        RESET = 1'b0;
        ref_stk.delete();
        last_res = 4'h0;
        @(negedge CLK);
        chk("rst_tok_ready", int'(TOK_READY), 1);
        chk("rst_depth", sp, 0);
    endtask

    task automatic idle(input int n);
        TOK_VALID = 1'b0;
        repeat (n) begin
            @(negedge CLK);
            chk("idle_res_valid", int'(RES_VALID), 0);
            chk("idle_res_data_hold", int'(RES_DATA), int'(last_res));
            chk("idle_stk_cmd", int'(STK_COMMAND), 0);
        end
    endtask

    // Send one token and check every cycle until the driver is idle again.
    task automatic do_token(input logic [1:0] op, input logic [3:0] data);
        int         depth;
        int         idx;
        int         lat;
        bit         err;
        bit         erv;
        int         a;
        int         b;
        logic [3:0] r;
        logic [1:0] ecmd;
        depth = ref_stk.size();
        idx   = int'(data[2:0]);
        err   = 1'b0;
        r     = 4'h0;
        case (op)
            2'd0: begin
                if (depth == 5) err = 1'b1;
                else ref_stk.push_back(data);
            end
            2'd1, 2'd2: begin
                if (depth < 2) err = 1'b1;
                else begin
                    b = int'(ref_stk.pop_back());
                    a = int'(ref_stk.pop_back());
                    if (op == 2'd1) r = 4'((a + b) % 16);
                    else            r = 4'((a - b + 16) % 16);
                    ref_stk.push_back(r);
                end
            end
            default: begin
                if (idx >= depth) err = 1'b1;
                else r = ref_stk[depth - 1 - idx];
            end
        endcase
        if (err)                         lat = 1;
        else if (op == 2'd1 || op == 2'd2) lat = 4;
        else                             lat = 2;

        chk("tok_ready_pre", int'(TOK_READY), 1);
        TOK_VALID = 1'b1;
        TOK_OP    = op;
        TOK_DATA  = data;
        @(posedge CLK);
        @(negedge CLK);
        TOK_VALID = 1'b0;
        TOK_OP    = 2'($urandom);
        TOK_DATA  = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge CLK);
            ecmd = 2'b00;
            if (!err) begin
                if (op == 2'd0 && k == 1)                        ecmd = 2'b01;
                else if ((op == 2'd1 || op == 2'd2) && k <= 2)   ecmd = 2'b10;
                else if ((op == 2'd1 || op == 2'd2) && k == 3)   ecmd = 2'b01;
                else if (op == 2'd3 && k == 1)                   ecmd = 2'b11;
            end
            erv = (k == lat) && (op != 2'd0 || err);
            chk("stk_cmd", int'(STK_COMMAND), int'(ecmd));
            if (ecmd == 2'b01)
                chk("stk_i_data", int'(STK_I_DATA), (op == 2'd0) ? int'(data) : int'(r));
            if (ecmd == 2'b11)
                chk("stk_index", int'(STK_INDEX), idx);
            chk("tok_ready", int'(TOK_READY), (k == lat) ? 1 : 0);
            chk("res_valid", int'(RES_VALID), int'(erv));
            if (erv) begin
                chk("res_err", int'(RES_ERR), int'(err));
                last_res = err ? 4'h0 : r;
            end
            chk("res_data", int'(RES_DATA), int'(last_res));
        end
        chk("depth", sp, ref_stk.size());
        for (int i = 0; i < ref_stk.size() && i < 8; i++)
            chk("stk_content", int'(smem[3'(i)]), int'(ref_stk[i]));
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    // Directed scenarios followed by randomized tokens.
    initial begin
        RESET     = 1'b1;
        TOK_VALID = 1'b0;
        TOK_OP    = 2'b00;
        TOK_DATA  = 4'h0;
        @(negedge CLK);
        do_reset();

        do_token(2'd0, 4'd3);
        do_token(2'd0, 4'd5);
        do_token(2'd1, 4'd0);
        chk("plan_add_8", int'(RES_DATA), 8);
        chk("plan_add_depth1", sp, 1);

        do_reset();
        do_token(2'd0, 4'd2);
        do_token(2'd0, 4'd7);
        do_token(2'd2, 4'd0);
        chk("plan_sub_11", int'(RES_DATA), 11);
        do_token(2'd3, 4'd0);
        chk("plan_peek_11", int'(RES_DATA), 11);

        do_reset();
        do_token(2'd0, 4'd1);
        do_token(2'd0, 4'd2);
        do_token(2'd0, 4'd3);
        do_token(2'd3, 4'd0);
        chk("plan_peek0_3", int'(RES_DATA), 3);
        do_token(2'd3, 4'd2);
        chk("plan_peek2_1", int'(RES_DATA), 1);
        do_token(2'd3, 4'd3);
        chk("plan_peek3_err", int'(RES_DATA), 0);
        chk("plan_peek_depth3", sp, 3);

        do_reset();
        for (int i = 0; i < 5; i++) do_token(2'd0, 4'(10 + i));
        do_token(2'd0, 4'd15);
        chk("plan_full_depth5", sp, 5);
        do_token(2'd3, 4'd4);
        chk("plan_peek4_first", int'(RES_DATA), 10);

        do_reset();
        do_token(2'd1, 4'd0);
        do_token(2'd0, 4'd9);
        do_token(2'd2, 4'd0);
        chk("plan_sub_err_depth1", sp, 1);
        do_token(2'd3, 4'd0);
        chk("plan_peek_9", int'(RES_DATA), 9);

        do_reset();
        do_token(2'd0, 4'd4);
        do_token(2'd0, 4'd6);
        chk("abort_ready", int'(TOK_READY), 1);
        TOK_VALID = 1'b1;
        TOK_OP    = 2'd1;
        TOK_DATA  = 4'd0;
        @(posedge CLK);
        @(negedge CLK);
        TOK_VALID = 1'b0;
        chk("abort_pop_b", int'(STK_COMMAND), 2);
        @(negedge CLK);
        chk("abort_pop_a", int'(STK_COMMAND), 2);
        RESET = 1'b1;
        #1;
        chk("abort_stk_reset", int'(STK_RESET), 1);
        @(negedge CLK);
        RESET = 1'b0;
        ref_stk.delete();
        last_res = 4'h0;
        chk("abort_no_result", int'(RES_VALID), 0);
        chk("abort_cmd_idle", int'(STK_COMMAND), 0);
        chk("abort_ready_after", int'(TOK_READY), 1);
        chk("abort_stack_clear", sp, 0);
        do_token(2'd3, 4'd0);
        chk("abort_peek_err", int'(RES_DATA), 0);

        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [1:0] rop;
            logic [3:0] rdata;
            rop   = 2'($urandom_range(0, 3));
            rdata = 4'($urandom);
            do_token(rop, rdata);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
